acc_unit: RTL and testbench

Accumulator/register stage sitting directly downstream of the `mul` ALU block. It latches the operand (immediate or from an inter-node port handshake) onto the multiplier's `arg1` input. It drives the multiplier's `acc` input from its own ACC register and writes results back with ±999 saturation. It owns ACC and BAK and executes one accumulator instruction at a time under a valid/ready handshake.

---
 rtl/sm_pkg.sv | 38 +++
 rtl/sat_clamp.sv | 23 ++
 rtl/acc_unit.sv | 139 +++++++++++++
 tb/tb_acc_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared types for the accumulator stage: word size, saturation bound,
// opcode and state encodings, and the operand-use decoder.
package sm_pkg;

  localparam int WORD_W  = 11;
  localparam int SAT_MAX = 999;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_MOV = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_MUL = 3'd4,
    OP_NEG = 3'd5,
    OP_SWP = 3'd6,
    OP_SAV = 3'd7
  } acc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } acc_st_t;

  function automatic logic op_uses_arg(
    input acc_op_t op
  );
    logic r;
    r = 1'b0;
    unique case (op)
      OP_MOV, OP_ADD,
      OP_SUB, OP_MUL: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational saturator: (WORD_W+1)-bit signed in, WORD_W-bit out
// clamped to [-SAT_MAX, +SAT_MAX]. Ports: din, dout.
module sat_clamp
  import sm_pkg::*;
(
  input  logic signed [WORD_W:0]   din,
  output logic signed [WORD_W-1:0] dout
);

  localparam logic signed [WORD_W:0] HI =
    (WORD_W+1)'(SAT_MAX);
  localparam logic signed [WORD_W:0] LO = -HI;

  always_comb begin
    dout = din[WORD_W-1:0];
    if (din > HI) begin
      dout = HI[WORD_W-1:0];
    end else if (din < LO) begin
      dout = LO[WORD_W-1:0];
    end
  end

endmodule

// File: rtl/acc_unit.sv
// Accumulator stage downstream of mul: owns ACC/BAK, latches the operand
// onto mul.arg1, runs one instruction per valid/ready handshake.
// Ports: clk, rst_n, instr_* (valid/ready/op/src/imm), port_* (valid/
// ready/data), mul_out, acc_o, arg1_o, bak_o, done.
module acc_unit
  import sm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic              instr_src,
  input  logic [WORD_W-1:0] instr_imm,
  input  logic              port_valid,
  output logic              port_ready,
  input  logic [WORD_W-1:0] port_data,
  input  logic [WORD_W-1:0] mul_out,
  output logic [WORD_W-1:0] acc_o,
  output logic [WORD_W-1:0] arg1_o,
  output logic [WORD_W-1:0] bak_o,
  output logic              done
);

  acc_st_t st_q, st_d;
  acc_op_t op_q, op_in;

  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] bak_q;
  logic [WORD_W-1:0] arg_q;
  logic              done_q;
  logic              load_arg;

  logic [WORD_W-1:0] cap_raw;
  logic [WORD_W:0]   cap_ext;
  logic [WORD_W-1:0] cap_sat;
  logic [WORD_W:0]   acc_ext;
  logic [WORD_W:0]   arg_ext;
  logic [WORD_W:0]   sum;
  logic [WORD_W-1:0] sum_sat;

  assign op_in = acc_op_t'(instr_op);

  // One clamp serves both capture paths; FETCH selects the port word.
  assign cap_raw = (st_q == ST_FETCH) ?
                   port_data : instr_imm;
  assign cap_ext = {cap_raw[WORD_W-1], cap_raw};

  sat_clamp u_cap (
    .din  (cap_ext),
    .dout (cap_sat)
  );

  assign acc_ext = {acc_q[WORD_W-1], acc_q};
  assign arg_ext = {arg_q[WORD_W-1], arg_q};
  assign sum = (op_q == OP_SUB) ?
               acc_ext - arg_ext :
               acc_ext + arg_ext;

  sat_clamp u_res (
    .din  (sum),
    .dout (sum_sat)
  );

  always_comb begin
    st_d        = st_q;
    instr_ready = 1'b0;
    port_ready  = 1'b0;
    load_arg    = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (op_uses_arg(op_in) && instr_src) begin
            st_d = ST_FETCH;
          end else begin
            load_arg = op_uses_arg(op_in);
            st_d     = ST_EXEC;
          end
        end
      end
      ST_FETCH: begin
        port_ready = 1'b1;
        if (port_valid) begin
          load_arg = 1'b1;
          st_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      op_q   <= OP_NOP;
      acc_q  <= '0;
      bak_q  <= '0;
      arg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      done_q <= (st_q == ST_EXEC);
      if (st_q == ST_IDLE && instr_valid) begin
        op_q <= op_in;
      end
      if (load_arg) begin
        arg_q <= cap_sat;
      end
      if (st_q == ST_EXEC) begin
        unique case (op_q)
          OP_NOP: ;
          OP_MOV: acc_q <= arg_q;
          OP_ADD: acc_q <= sum_sat;
          OP_SUB: acc_q <= sum_sat;
          OP_MUL: acc_q <= mul_out;
          OP_NEG: acc_q <= -acc_q;
          OP_SWP: begin
            acc_q <= bak_q;
            bak_q <= acc_q;
          end
          OP_SAV: bak_q <= acc_q;
          default: ;
        endcase
      end
    end
  end

  assign acc_o  = acc_q;
  assign bak_o  = bak_q;
  assign arg1_o = arg_q;
  assign done   = done_q;

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit with a behavioural saturating multiplier
// standing in for mul.
module tb_acc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic        instr_src;
  logic [10:0] instr_imm;
  logic        port_valid;
  logic        port_ready;
  logic [10:0] port_data;
  logic [10:0] mul_out;
  logic [10:0] acc_o;
  logic [10:0] arg1_o;
  logic [10:0] bak_o;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_src   (instr_src),
    .instr_imm   (instr_imm),
    .port_valid  (port_valid),
    .port_ready  (port_ready),
    .port_data   (port_data),
    .mul_out     (mul_out),
    .acc_o       (acc_o),
    .arg1_o      (arg1_o),
    .bak_o       (bak_o),
    .done        (done)
  );

  function automatic int sx(input logic [10:0] v);
    return int'($signed(v));
  endfunction

  int prod;
  int prod_sat;
  always_comb begin
    prod     = sx(acc_o) * sx(arg1_o);
    prod_sat = prod;
    if (prod > 999) prod_sat = 999;
    else if (prod < -999) prod_sat = -999;
    mul_out = prod_sat[10:0];
  end

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_imm(input string tag,
                         input logic [2:0] op,
                         input int imm,
                         input int exp_acc);
    @(negedge clk);
    check({tag, ":rdy"}, int'(instr_ready), 1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_src   = 1'b0;
    instr_imm   = imm[10:0];
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_imm   = 11'h2aa;
    check({tag, ":busy"}, int'(instr_ready), 0);
    check({tag, ":d0"}, int'(done), 0);
    @(posedge clk);
    #1;
    check({tag, ":d1"}, int'(done), 1);
    check({tag, ":acc"}, sx(acc_o), exp_acc);
    @(posedge clk);
    #1;
    check({tag, ":d2"}, int'(done), 0);
  endtask

  int stall;
  int v;

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 3'd0;
    instr_src   = 1'b0;
    instr_imm   = '0;
    port_valid  = 1'b0;
    port_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_acc", sx(acc_o), 0);
    check("rst_bak", sx(bak_o), 0);
    check("rst_arg", sx(arg1_o), 0);
    check("rst_done", int'(done), 0);
    check("rst_irdy", int'(instr_ready), 1);
    check("rst_prdy", int'(port_ready), 0);

    run_imm("mov3", 3'd1, 3, 3);
    run_imm("mul7", 3'd4, 7, 21);

    run_imm("mov_m5", 3'd1, -5, -5);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 3'd4;
    instr_src   = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_src   = 1'b0;
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      if (port_ready) stall++;
      @(posedge clk);
      #1;
    end
    check("port_stall", stall, 4);
    check("port_rdy5", int'(port_ready), 1);
    check("stall_done", int'(done), 0);
    v = -17;
    port_valid = 1'b1;
    port_data  = v[10:0];
    @(posedge clk);
    #1;
    port_valid = 1'b0;
    check("port_arg", sx(arg1_o), -17);
    check("port_d0", int'(done), 0);
    check("port_prdy0", int'(port_ready), 0);
    @(posedge clk);
    #1;
    check("port_d1", int'(done), 1);
    check("port_acc", sx(acc_o), 85);

    run_imm("mov900", 3'd1, 900, 900);
    run_imm("add500", 3'd2, 500, 999);
    run_imm("movm900", 3'd1, -900, -900);
    run_imm("sub500", 3'd3, 500, -999);
    run_imm("movm1024", 3'd1, -1024, -999);
    check("arg_m1024", sx(arg1_o), -999);
    run_imm("mov1020", 3'd1, 1020, 999);
    check("arg_1020", sx(arg1_o), 999);

    run_imm("mov42", 3'd1, 42, 42);
    run_imm("sav", 3'd7, 0, 42);
    check("sav_bak", sx(bak_o), 42);
    run_imm("mov7", 3'd1, 7, 7);
    run_imm("swp", 3'd6, 0, 42);
    check("swp_bak", sx(bak_o), 7);
    run_imm("neg", 3'd5, 0, -42);
    run_imm("nop", 3'd0, 55, -42);
    check("nop_arg", sx(arg1_o), 7);
    check("nop_bak", sx(bak_o), 7);

    run_imm("mov136", 3'd1, 136, 136);
    run_imm("mul492", 3'd4, 492, 999);
    run_imm("mov844", 3'd1, 844, 844);
    run_imm("mulm91", 3'd4, -91, -999);

    @(negedge clk);
    port_valid = 1'b1;
    port_data  = 11'd5;
    #1;
    check("idle_prdy", int'(port_ready), 0);
    @(posedge clk);
    #1;
    check("idle_port_arg", sx(arg1_o), -91);
    port_valid = 1'b0;

    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 3'd1;
    instr_src   = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("fetch_prdy", int'(port_ready), 1);
    port_valid = 1'b1;
    port_data  = 11'd77;
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_acc", sx(acc_o), 0);
    check("ar_bak", sx(bak_o), 0);
    check("ar_arg", sx(arg1_o), 0);
    check("ar_prdy", int'(port_ready), 0);
    check("ar_done", int'(done), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_prdy", int'(port_ready), 0);
      check("post_done", int'(done), 0);
      check("post_irdy", int'(instr_ready), 1);
      check("post_acc", sx(acc_o), 0);
    end
    port_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
